// File: rtl/pulse_stretch_if.sv
// Event/pulse bus of the pulse stretcher: the event input plus the stretched
// output and its status flags.
interface pulse_stretch_if #(
  parameter int PEND_W = 2
);
  logic              inp;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output inp, input out, busy, pending, overflow);
  modport slave  (input inp, output out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretch.sv
// Turns rising edges on inp into fixed-length output pulses with a guaranteed
// low gap; events arriving while a pulse is in progress are queued.
module pulse_stretch #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4,
  parameter int CNT_W      = 16,
  parameter int PEND_W     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pulse_stretch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              prev_q;
  logic              armed_q;
  logic              ev;
  logic              queueEv;
  logic              startFromQueue;

  // armed_q masks the first edge after reset so a level already high is not an event.
  assign ev = armed_q & bus.inp & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      prev_q     <= bus.inp;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    out_d          = out_q;
    pending_d      = pending_q;
    overflow_d     = overflow_q;
    queueEv        = 1'b0;
    startFromQueue = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = ON;
          timer_d = ON_LOAD;
          out_d   = 1'b1;
        end
      end
      ON: begin
        queueEv = ev;
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = GAP;
          timer_d = OFF_LOAD;
          out_d   = 1'b0;
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
          queueEv = ev;
        end else if (pending_q != '0) begin
          state_d        = ON;
          timer_d        = ON_LOAD;
          out_d          = 1'b1;
          startFromQueue = 1'b1;
          queueEv        = ev;
        end else if (ev) begin
          // An event landing exactly at the end of the gap starts the next pulse directly.
          state_d = ON;
          timer_d = ON_LOAD;
          out_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
      end
    endcase

    if (queueEv && !startFromQueue) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!queueEv && startFromQueue) begin
      pending_d = pending_q - 1'b1;
    end
  end

  assign busy_d = (state_d != IDLE);

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Randomized and directed checks of pulse_stretch against an event-list model
// that predicts each pulse's start cycle from the event times.
module tb_pulse_stretch;

  localparam int ON     = 8;
  localparam int OFF    = 4;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errs;
  int   cyc;

  // Model state: accepted event cycles and their pulse start cycles.
  int   evT[$];
  int   evS[$];
  int   dropT;
  int   relCycle;
  bit   prevInp;

  pulse_stretch_if #(.PEND_W(PEND_W)) bus ();

  pulse_stretch #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .CNT_W     (16),
    .PEND_W    (PEND_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PEND_W+2:0] modelExpect(int c);
    int   pend;
    logic o;
    logic b;
    pend = 0;
    o    = 1'b0;
    b    = 1'b0;
    foreach (evS[i]) begin
      if (c >= evS[i] && c < evS[i] + ON) o = 1'b1;
      if (c >= evS[i] && c < evS[i] + ON + OFF) b = 1'b1;
      if (evT[i] < c && c < evS[i]) pend++;
    end
    return {o, b, PEND_W'(pend), (dropT >= 0 && dropT < c)};
  endfunction

  task automatic modelEvent(input int c, input bit v);
    bit ev;
    int s;
    int cnt;
    ev      = (c > relCycle) && v && !prevInp;
    prevInp = v;
    if (ev) begin
      s = c + 1;
      if (evS.size() > 0 && evS[$] + ON + OFF > s) s = evS[$] + ON + OFF;
      cnt = 0;
      foreach (evS[i]) if (evT[i] < c + 1 && c + 1 < evS[i]) cnt++;
      if (s == c + 1 || cnt < PMAX) begin
        evT.push_back(c);
        evS.push_back(s);
      end else if (dropT < 0) begin
        dropT = c;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // One cycle: drive inp, predict, sample mid-cycle, then log the event.
  task automatic advance(input bit v, output logic [PEND_W+2:0] exp,
                         output logic [PEND_W+2:0] got);
    int c;
    tick();
    bus.inp = v;
    c       = cyc;
    exp     = modelExpect(c);
    @(negedge clk);
    got = {bus.out, bus.busy, bus.pending, bus.overflow};
    modelEvent(c, v);
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    evT.delete();
    evS.delete();
    dropT = -1;
    #1;
  endtask

  task automatic releaseReset(input bit v, input int n);
    bus.inp = v;
    repeat (n) tick();
    rst_n    = 1'b1;
    relCycle = cyc;
    prevInp  = v;
  endtask

  task automatic test_reset();
    logic [PEND_W+2:0] exp, got;
    assertReset();
    got = {bus.out, bus.busy, bus.pending, bus.overflow};
    checks++;
    if (got !== '0) begin
      $display("FAIL reset_state: got %b required %b", got, 5'b0);
      errs++;
    end
    releaseReset(1'b1, 3);
    for (int i = 0; i < 20; i++) begin
      advance(1'b1, exp, got);
      checks++;
      if (got !== exp) begin
        $display("FAIL reset_release_high cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
    advance(1'b0, exp, got);
  endtask

  task automatic test_single_strobe();
    logic [PEND_W+2:0] exp, got;
    int highCnt;
    int busyCnt;
    highCnt = 0;
    busyCnt = 0;
    for (int i = 0; i < 30; i++) begin
      advance(i == 3, exp, got);
      highCnt += int'(got[PEND_W+2]);
      busyCnt += int'(got[PEND_W+1]);
      checks++;
      if (got !== exp) begin
        $display("FAIL single_strobe cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
    checks++;
    if (highCnt != ON || busyCnt != ON + OFF) begin
      $display("FAIL single_strobe_len: high %0d busy %0d required %0d %0d",
               highCnt, busyCnt, ON, ON + OFF);
      errs++;
    end
  endtask

  task automatic test_held_level();
    logic [PEND_W+2:0] exp, got;
    int rises;
    logic lastOut;
    rises   = 0;
    lastOut = 1'b0;
    for (int i = 0; i < 100; i++) begin
      advance(!(i == 50 || i >= 70), exp, got);
      if (got[PEND_W+2] && !lastOut) rises++;
      lastOut = got[PEND_W+2];
      checks++;
      if (got !== exp) begin
        $display("FAIL held_level cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
    checks++;
    if (rises != 2) begin
      $display("FAIL held_level_pulses: got %0d required 2", rises);
      errs++;
    end
  endtask

  task automatic test_back_to_back();
    logic [PEND_W+2:0] exp, got;
    for (int i = 0; i < 45; i++) begin
      advance(i == 0 || i == 2 || i == 4, exp, got);
      checks++;
      if (got !== exp) begin
        $display("FAIL back_to_back cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
  endtask

  task automatic test_overflow();
    logic [PEND_W+2:0] exp, got;
    int rises;
    logic lastOut;
    rises   = 0;
    lastOut = 1'b0;
    for (int i = 0; i < 70; i++) begin
      advance(i <= 10 && (i % 2 == 0), exp, got);
      if (got[PEND_W+2] && !lastOut) rises++;
      lastOut = got[PEND_W+2];
      checks++;
      if (got !== exp) begin
        $display("FAIL overflow cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
    checks++;
    if (rises != 4 || bus.overflow !== 1'b1) begin
      $display("FAIL overflow_total: pulses %0d ovf %b required 4 1", rises, bus.overflow);
      errs++;
    end
  endtask

  task automatic test_gap_end_strobe();
    logic [PEND_W+2:0] exp, got;
    bit sawPend;
    sawPend = 1'b0;
    assertReset();
    releaseReset(1'b0, 2);
    for (int i = 0; i < 40; i++) begin
      advance(i == 0 || i == ON + OFF, exp, got);
      if (got[PEND_W:1] != '0) sawPend = 1'b1;
      checks++;
      if (got !== exp) begin
        $display("FAIL gap_end cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
    checks++;
    if (sawPend) begin
      $display("FAIL gap_end_pending: got nonzero required 0");
      errs++;
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [PEND_W+2:0] exp, got;
    for (int i = 0; i < 7; i++) begin
      advance(i == 0 || i == 2 || i == 4, exp, got);
      checks++;
      if (got !== exp) begin
        $display("FAIL mid_reset_pre cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
    assertReset();
    got = {bus.out, bus.busy, bus.pending, bus.overflow};
    checks++;
    if (got !== '0) begin
      $display("FAIL mid_reset_drop: got %b required %b", got, 5'b0);
      errs++;
    end
    releaseReset(1'b0, 2);
    for (int i = 0; i < 30; i++) begin
      advance(1'b0, exp, got);
      checks++;
      if (got !== '0) begin
        $display("FAIL mid_reset_after cyc %0d: got %b required %b", i, got, 5'b0);
        errs++;
      end
    end
  endtask

  task automatic test_random();
    logic [PEND_W+2:0] exp, got;
    assertReset();
    releaseReset(1'b0, 2);
    for (int i = 0; i < 600; i++) begin
      advance($urandom_range(0, 9) < 3, exp, got);
      checks++;
      if (got !== exp) begin
        $display("FAIL random cyc %0d: got %b required %b", i, got, exp);
        errs++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    errs     = 0;
    cyc      = 0;
    dropT    = -1;
    relCycle = 0;
    prevInp  = 1'b0;
    rst_n    = 1'b1;
    bus.inp  = 1'b0;
    #2;
    test_reset();
    test_single_strobe();
    test_held_level();
    test_back_to_back();
    test_overflow();
    test_gap_end_strobe();
    test_reset_mid_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
